booth_iter_mul: RTL and testbench

- Sequential radix-4 Booth multiplier; the consumer end of the Booth partial-product path.
- Each cycle it recodes one 3-bit multiplier group, forms one partial product (0, ±X, ±2X; negation as invert plus carry-in) and accumulates it into a 2*WIDTH product.
- Valid/ready on both the operand and result sides.
- Area-cheap alternative to the Wallace-tree multiplier, for the ALU's multi-cycle MUL path.

---
 rtl/booth_iter_mul_if.sv | 26 ++
 rtl/booth_iter_mul.sv | 127 ++++++++++++
 tb/tb_booth_iter_mul.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/booth_iter_mul_if.sv
// Operand/result handshake bundle for booth_iter_mul.
// A transfer happens on a rising edge where valid && ready; the producer holds valid
// and its payload stable until then, and valid never waits on ready.
interface booth_iter_mul_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH-1:0]     in_x;
  logic [WIDTH-1:0]     in_y;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_result;
  logic                 busy;

  modport master (
    output in_valid, in_signed, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_signed, in_x, in_y, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/booth_iter_mul.sv
// Sequential radix-4 Booth multiplier: one recoded multiplier group per cycle.
// Define BOOTH_EARLY_TERM_EN to stop as soon as the remaining groups all decode to 0.
module booth_iter_mul #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                resetn,
  booth_iter_mul_if.slave     bus,
  output logic [1:0]          state_dbg
);

  localparam int CW = $clog2(WIDTH/2 + 2);
  localparam int PW = 2*WIDTH;
  localparam logic [CW-1:0] LAST_S = CW'(WIDTH/2 - 1);
  localparam logic [CW-1:0] LAST_U = CW'(WIDTH/2);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       x_q;
  logic [WIDTH+2:0]    y_q;      // bit 0 is the implicit y[-1]
  logic [PW-1:0]       acc_q;
  logic [PW-1:0]       result_q;
  logic [CW-1:0]       cnt_q;
  logic                signed_q;

  logic [CW:0]         sh;
  logic [WIDTH+2:0]    y_shift;
  logic [2:0]          grp;
  logic                neg;
  logic [PW-1:0]       x_sel;
  logic [PW-1:0]       pp;
  logic [PW-1:0]       cin;
  logic [PW-1:0]       acc_nxt;
  logic                last_iter;
  logic                finish;

  assign sh      = {cnt_q, 1'b0};
  assign y_shift = y_q >> sh;
  assign grp     = y_shift[2:0];

  always_comb begin
    x_sel = '0;
    neg   = 1'b0;
    case (grp)
      3'b001, 3'b010: x_sel = x_q;
      3'b011:         x_sel = {x_q[PW-2:0], 1'b0};
      3'b100: begin
        x_sel = {x_q[PW-2:0], 1'b0};
        neg   = 1'b1;
      end
      3'b101, 3'b110: begin
        x_sel = x_q;
        neg   = 1'b1;
      end
      default: x_sel = '0;
    endcase
  end

  // Negation is ~value plus a carry-in at the group's weight.
  assign pp      = (neg ? ~x_sel : x_sel) << sh;
  assign cin     = neg ? (PW'(1) << sh) : '0;
  assign acc_nxt = acc_q + pp + cin;

  assign last_iter = (cnt_q == (signed_q ? LAST_S : LAST_U));

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH+2:0] y_tail;
  logic             tail_uniform;
  // Remaining groups are all zero once every bit from 2(i+1)-1 upward matches the top bit.
  assign y_tail       = $signed(y_q) >>> (sh + (CW+1)'(2));
  assign tail_uniform = (y_tail == '0) || (&y_tail);
  assign finish       = last_iter || tail_uniform;
`else
  assign finish       = last_iter;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = BUSY;
      BUSY:    if (finish)       state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          x_q      <= bus.in_signed ? {{WIDTH{bus.in_x[WIDTH-1]}}, bus.in_x}
                                    : {{WIDTH{1'b0}}, bus.in_x};
          y_q      <= {{2{bus.in_signed & bus.in_y[WIDTH-1]}}, bus.in_y, 1'b0};
          signed_q <= bus.in_signed;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        BUSY: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (finish) result_q <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state == BUSY);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = result_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_booth_iter_mul.sv
// Directed bench for booth_iter_mul (WIDTH=32): vector table plus backpressure and reset sequences.
module tb_booth_iter_mul;

  localparam int W = 32;

  logic       clk;
  logic       resetn;
  logic [1:0] state_dbg;

  booth_iter_mul_if #(.WIDTH(W)) bus ();

  booth_iter_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  typedef struct {
    logic          sg;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [2*W-1:0] exp;
    int            lat_full;
    int            lat_early;
  } vec_t;

  vec_t vecs[14];

  logic [2*W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick_lat(input int lat_full, input int lat_early);
`ifdef BOOTH_EARLY_TERM_EN
    return lat_early;
`else
    return lat_full;
`endif
  endfunction

  // Count edges after the accept edge until out_valid; check latency and result.
  task automatic wait_result(input string name, input int lat);
    int  k;
    bit  got;
    logic [2*W-1:0] e;
    got = 0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: no out_valid within 40 edges, required %0d", name, lat);
      void'(exp_q.pop_front());
    end else begin
      chk({name, " latency"}, 64'(k), 64'(lat));
      e = exp_q.pop_front();
      chk({name, " result"}, bus.out_result, e);
    end
  endtask

  task automatic run_op(input string name, input logic sg, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [2*W-1:0] exp, input int lat);
    int k;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_signed = sg;
    bus.in_x      = x;
    bus.in_y      = y;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({name, " in_ready"}, 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    exp_q.push_back(exp);
    bus.in_valid  = 1'b0;
    bus.in_x      = $urandom;
    bus.in_y      = $urandom;
    bus.in_signed = 1'($urandom_range(0, 1));
    chk({name, " busy"}, 64'(bus.busy), 64'(1));
    wait_result(name, lat);
    @(posedge clk); #1;
    chk({name, " handoff"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
  endtask

  initial begin
    int lat;
    bit saw_valid;

    vecs[0]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 16, 1};
    vecs[1]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 16, 16};
    vecs[2]  = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 16, 16};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 17, 17};
    vecs[4]  = '{1'b0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 17, 2};
    vecs[5]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 16, 1};
    vecs[6]  = '{1'b1, 32'h0000_0002, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 16, 2};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 17, 2};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'h0000_1234, 64'h0000_0000_0000_0000, 16, 7};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFB, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFE2, 16, 2};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 17, 1};
    vecs[11] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 16, 16};
    vecs[12] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 17, 17};
    vecs[13] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000, 16, 16};

    // reset
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset flags", {60'd0, bus.in_ready, bus.out_valid, bus.busy, 1'b0}, 64'b1000);
    chk("reset result", bus.out_result, 64'd0);
    chk("reset state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // vector table
    for (int i = 0; i < 14; i++) begin
      lat = pick_lat(vecs[i].lat_full, vecs[i].lat_early);
      run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].x, vecs[i].y, vecs[i].exp, lat);
    end

    // backpressure with in_valid held during DONE
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_signed = 1'b0;
    bus.in_x      = 32'd3;
    bus.in_y      = 32'd5;
    chk("bp in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    exp_q.push_back(64'd15);
    bus.in_valid = 1'b0;
    wait_result("bp op", pick_lat(17, 2));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_signed = 1'b1;
      bus.in_x      = 32'd2;
      bus.in_y      = 32'hFFFF_FFFD;
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d flags", c), {62'd0, bus.out_valid, bus.in_ready}, 64'b10);
      chk($sformatf("bp hold%0d result", c), bus.out_result, 64'd15);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    @(posedge clk); #1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    bus.in_valid = 1'b0;
    chk("bp pending taken", 64'(bus.busy), 64'(1));
    wait_result("bp pending op", pick_lat(16, 2));
    @(posedge clk); #1;
    chk("bp pending handoff", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);

    // reset during BUSY iteration 7
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_signed = 1'b1;
    bus.in_x      = 32'h8000_0000;
    bus.in_y      = 32'h8000_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("rst pre busy", 64'(bus.busy), 64'(1));
    resetn = 1'b0;
    #1;
    chk("rst mid flags", {60'd0, bus.in_ready, bus.out_valid, bus.busy, 1'b0}, 64'b1000);
    chk("rst mid result", bus.out_result, 64'd0);
    chk("rst mid state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    saw_valid = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1;
    end
    chk("rst no result", 64'(saw_valid), 64'd0);
    run_op("post rst", 1'b1, 32'd2, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, pick_lat(16, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
